// File: rtl/spi_frame_pkg.sv
// spi_frame_pkg: shared word width, CRC-32/BZIP2 constants and frame FSM state type
package spi_frame_pkg;
  localparam int WORD_W = 32;
  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT_DEF = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT_DEF = 32'hFFFFFFFF;
  typedef enum logic [1:0] {IDLE, CRC, DONE} state_t;
endpackage

// File: rtl/crc32_byte.sv
// crc32_byte: combinational CRC-32 (poly 04C11DB7, MSB-first) update by one byte; crc_in, data -> crc_out
module crc32_byte
  import spi_frame_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = 7; i >= 0; i--)
      crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC32_POLY : 32'h0);
  end
endmodule

// File: rtl/spi_frame_builder.sv
// spi_frame_builder: freezes data_in on synchronized ssel fall into frame and appends CRC-32/BZIP2 when SPI_FRAME_CRC_EN is defined; clk, reset, ssel, data_in -> frame, frame_valid, busy, snap_count
module spi_frame_builder
  import spi_frame_pkg::*;
#(
  parameter int NUM_WORDS = 6,
  parameter int SYNC_STAGES = 2,
  parameter logic [31:0] CRC_INIT = CRC_INIT_DEF,
  parameter logic [31:0] CRC_XOROUT = CRC_XOROUT_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              ssel,
  input  logic [WORD_W*NUM_WORDS-1:0]       data_in,
  output logic [WORD_W*(NUM_WORDS+1)-1:0]   frame,
  output logic                              frame_valid,
  output logic                              busy,
  output logic [7:0]                        snap_count
);
  localparam int NB = 4 * NUM_WORDS;
  localparam int FW = WORD_W * (NUM_WORDS + 1);
  logic [SYNC_STAGES-1:0] sync;
  logic prev, snap;
  state_t state, state_next;
  assign snap = prev & ~sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= '1;
      prev <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], ssel};
      prev <= sync[SYNC_STAGES-1];
    end
  end
  always_ff @(posedge clk) state <= reset ? IDLE : state_next;
`ifdef SPI_FRAME_CRC_EN
  localparam int CW = $clog2(NB);
  logic [CW-1:0] cnt;
  logic [31:0] crc, crc_next;
  logic [7:0] cur;
  logic last;
  assign last = cnt == CW'(NB - 1);
  // bytes are taken straight from the frozen frame, MSB byte of word 0 first
  assign cur = frame[FW - 1 - 8 * int'(cnt) -: 8];
  assign busy = state == CRC;
  always_comb state_next = snap ? CRC : (state == CRC && last) ? DONE : state;
  crc32_byte u_crc (.crc_in(crc), .data(cur), .crc_out(crc_next));
  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      frame_valid <= 1'b0;
      snap_count <= '0;
      cnt <= '0;
      crc <= '0;
    end else if (snap) begin
      frame <= {data_in, 32'h0};
      frame_valid <= 1'b0;
      snap_count <= snap_count + 8'd1;
      cnt <= '0;
      crc <= CRC_INIT;
    end else if (state == CRC) begin
      crc <= crc_next;
      cnt <= last ? cnt : cnt + CW'(1);
    end else if (state == DONE) begin
      frame[31:0] <= crc ^ CRC_XOROUT;
      frame_valid <= 1'b1;
    end
  end
`else
  assign busy = 1'b0;
  always_comb state_next = snap ? DONE : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      frame <= '0;
      frame_valid <= 1'b0;
      snap_count <= '0;
    end else if (snap) begin
      frame <= {data_in, 32'h0};
      frame_valid <= 1'b0;
      snap_count <= snap_count + 8'd1;
    end else if (state == DONE) begin
      frame_valid <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_spi_frame_builder.sv
// tb_spi_frame_builder: randomized self-checking bench for spi_frame_builder against a bitwise CRC-32/BZIP2 model
module tb_spi_frame_builder;
`ifdef SPI_FRAME_CRC_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int EXP_SNAP = 3;
  localparam int EXP_BUSY = CRC_ON ? 24 : 0;
  localparam int EXP_VALID = CRC_ON ? 25 : 1;
  logic clk = 1'b0, reset = 1'b1, ssel = 1'b1;
  logic [191:0] data_in = '0;
  logic [223:0] frame;
  logic frame_valid, busy;
  logic [7:0] snap_count;
  int checks = 0, failures = 0;
  spi_frame_builder dut (
    .clk(clk), .reset(reset), .ssel(ssel), .data_in(data_in),
    .frame(frame), .frame_valid(frame_valid), .busy(busy), .snap_count(snap_count)
  );
  always #10 clk = ~clk;
  function automatic logic [31:0] model_crc(input logic [191:0] d);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 191; i >= 0; i--)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return CRC_ON ? c ^ 32'hFFFFFFFF : 32'h0;
  endfunction
  function automatic logic [191:0] rnd192();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction
  task automatic wait_snap(input logic [7:0] sc0, output int lat);
    lat = 0;
    while (snap_count === sc0 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
  endtask
  task automatic measure(input bit scr, output int busy_cyc, output int lat_valid);
    busy_cyc = 0;
    lat_valid = 0;
    while (frame_valid !== 1'b1 && lat_valid < 40) begin
      if (busy === 1'b1) busy_cyc++;
      if (scr) data_in = rnd192();
      @(posedge clk); #1; lat_valid++;
    end
  endtask
  task automatic release_ssel();
    @(negedge clk); ssel = 1'b1;
    repeat (4) @(posedge clk);
  endtask
  task automatic run_frame(input logic [191:0] d, input bit scr, output int ls, output int bc, output int lv);
    logic [7:0] sc0;
    @(negedge clk);
    data_in = d;
    ssel = 1'b0;
    sc0 = snap_count;
    wait_snap(sc0, ls);
    measure(scr, bc, lv);
  endtask
  task automatic check_frame(input string name, input logic [191:0] d, input int ls, input int bc, input int lv);
    checks++; if (ls !== EXP_SNAP) begin failures++; $display("FAIL %s snap_latency got %0d want %0d", name, ls, EXP_SNAP); end
    checks++; if (bc !== EXP_BUSY) begin failures++; $display("FAIL %s busy_cycles got %0d want %0d", name, bc, EXP_BUSY); end
    checks++; if (lv !== EXP_VALID) begin failures++; $display("FAIL %s valid_latency got %0d want %0d", name, lv, EXP_VALID); end
    checks++; if (frame[223:32] !== d) begin failures++; $display("FAIL %s data_words got %h want %h", name, frame[223:32], d); end
    checks++; if (frame[31:0] !== model_crc(d)) begin failures++; $display("FAIL %s crc got %h want %h", name, frame[31:0], model_crc(d)); end
  endtask
  task automatic test_reset();
    int busy_seen = 0;
    reset = 1'b1;
    ssel = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    repeat (100) begin
      @(posedge clk); #1;
      if (busy !== 1'b0) busy_seen++;
    end
    checks++; if (busy_seen != 0) begin failures++; $display("FAIL reset_busy got %0d cycles want 0", busy_seen); end
    checks++; if (frame !== '0) begin failures++; $display("FAIL reset_frame got %h want 0", frame); end
    checks++; if (frame_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got %b want 0", frame_valid); end
    checks++; if (snap_count !== 8'd0) begin failures++; $display("FAIL reset_count got %0d want 0", snap_count); end
  endtask
  task automatic test_zero();
    int ls, bc, lv;
    run_frame('0, 1'b0, ls, bc, lv);
    check_frame("zero", '0, ls, bc, lv);
    checks++; if (snap_count !== 8'd1) begin failures++; $display("FAIL zero_count got %0d want 1", snap_count); end
    release_ssel();
  endtask
  task automatic test_hold();
    int ls, bc, lv;
    logic [191:0] d = {32'h00000001, 32'h12345678, 32'hFFFFFFFF, 32'h80000000, 32'h0000FFFF, 32'hDEADBEEF};
    run_frame(d, 1'b1, ls, bc, lv);
    check_frame("hold", d, ls, bc, lv);
    repeat (5) begin @(posedge clk); #1; data_in = rnd192(); end
    checks++; if (frame[223:32] !== d || frame_valid !== 1'b1) begin failures++; $display("FAIL hold_after got %h/%b want %h/1", frame[223:32], frame_valid, d); end
    release_ssel();
  endtask
  task automatic test_random();
    int ls, bc, lv;
    logic [191:0] d;
    for (int i = 0; i < 4; i++) begin
      d = rnd192();
      run_frame(d, 1'b1, ls, bc, lv);
      check_frame("random", d, ls, bc, lv);
      release_ssel();
    end
  endtask
  task automatic test_restart();
    int ls, bc, lv;
    logic [7:0] sc0;
    logic [191:0] d1 = rnd192(), d2 = rnd192();
    @(negedge clk);
    sc0 = snap_count;
    data_in = d1;
    ssel = 1'b0;
    wait_snap(sc0, ls);
    repeat (10) @(posedge clk);
    @(negedge clk); ssel = 1'b1; data_in = d2;
    repeat (3) @(negedge clk);
    ssel = 1'b0;
    wait_snap(sc0 + 8'd1, ls);
    measure(1'b0, bc, lv);
    check_frame("restart", d2, ls, bc, lv);
    checks++; if (snap_count !== sc0 + 8'd2) begin failures++; $display("FAIL restart_count got %0d want %0d", snap_count, sc0 + 8'd2); end
    release_ssel();
  endtask
  task automatic test_reset_mid();
    int ls, bc, lv;
    logic [7:0] sc0;
    logic [191:0] d = rnd192();
    @(negedge clk);
    sc0 = snap_count;
    data_in = d;
    ssel = 1'b0;
    wait_snap(sc0, ls);
    repeat (12) @(posedge clk);
    @(negedge clk); reset = 1'b1; ssel = 1'b1;
    @(posedge clk); #1;
    checks++; if (frame !== '0 || frame_valid !== 1'b0 || busy !== 1'b0 || snap_count !== 8'd0) begin
      failures++; $display("FAIL midreset_outputs got frame=%h valid=%b busy=%b count=%0d want all 0", frame, frame_valid, busy, snap_count);
    end
    @(negedge clk); reset = 1'b0;
    repeat (3) @(posedge clk);
    d = rnd192();
    run_frame(d, 1'b0, ls, bc, lv);
    check_frame("after_reset", d, ls, bc, lv);
    checks++; if (snap_count !== 8'd1) begin failures++; $display("FAIL after_reset_count got %0d want 1", snap_count); end
    release_ssel();
  endtask
  task automatic test_wrap();
    int bad = 0;
    logic [7:0] expc;
    expc = snap_count;
    while (expc != 8'd0) begin
      @(negedge clk); ssel = 1'b0;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      ssel = 1'b1;
      repeat ($urandom_range(3, 5)) @(negedge clk);
      expc++;
      if (snap_count !== expc) bad++;
    end
    checks++; if (bad != 0) begin failures++; $display("FAIL wrap_per_edge got %0d bad pulses want 0", bad); end
    checks++; if (snap_count !== 8'd0) begin failures++; $display("FAIL wrap_count got %0d want 0", snap_count); end
  endtask
  initial begin
    test_reset();
    test_zero();
    test_hold();
    test_random();
    test_restart();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
